pipe_fwd_buffer: RTL

//  Parametrised execute->memory/writeback pipeline buffer with built-in operand forwarding.

---
 rtl/pipe_fwd_buffer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipe_fwd_buffer.sv
// DEPTH-slot execute->memory/writeback buffer that forwards in-flight results to NUM_SRC operands.
// Optional macro PIPE_FWD_LOAD_STALL_EN: a slot-0 load-use requests a stall instead of forwarding mem_dout.
module pipe_fwd_buffer #(
  parameter int DBITS               = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int DEPTH               = 1,
  parameter int NUM_SRC             = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  input  logic [DBITS-1:0]                       in_alu,
  input  logic [DBITS-1:0]                       in_st_data,
  input  logic [DBITS-1:0]                       in_pc_inc,
  input  logic                                   in_mem_wr,
  input  logic                                   in_mem_to_reg,
  input  logic                                   in_jal,
  input  logic                                   in_reg_wr,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]         in_dr,
  input  logic                                   hold,
  input  logic                                   flush,
  input  logic [NUM_SRC*REG_INDEX_BIT_WIDTH-1:0] src_idx,
  input  logic [NUM_SRC*DBITS-1:0]               src_rf,
  input  logic [DBITS-1:0]                       mem_dout,
  output logic [NUM_SRC*DBITS-1:0]               fwd_data,
  output logic [NUM_SRC-1:0]                     fwd_hit,
  output logic [DBITS-1:0]                       mem_addr,
  output logic [DBITS-1:0]                       mem_din,
  output logic                                   mem_wrt_en,
  output logic                                   wb_wrt_en,
  output logic [REG_INDEX_BIT_WIDTH-1:0]         wb_dr,
  output logic [DBITS-1:0]                       wb_data,
  output logic                                   hazard_stall
);
  localparam int RW   = REG_INDEX_BIT_WIDTH;
  localparam int LAST = DEPTH - 1;

  logic             slotVld      [DEPTH];
  logic             slotMemToReg [DEPTH];
  logic             slotRegWr    [DEPTH];
  logic [RW-1:0]    slotDr       [DEPTH];
  logic [DBITS-1:0] slotResult   [DEPTH];
  logic [DBITS-1:0] slotValue    [DEPTH];
  logic             headMemWr;
  logic [DBITS-1:0] headAlu;
  logic [DBITS-1:0] headStData;
  logic             acceptVld;
`ifdef PIPE_FWD_LOAD_STALL_EN
  logic [NUM_SRC-1:0] loadMatch;
`endif

  assign acceptVld = in_valid & ~flush & ~hazard_stall;

  // A load's value only exists on mem_dout while it sits in slot 0.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) slotValue[k] = slotResult[k];
    if (slotMemToReg[0]) slotValue[0] = mem_dout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        slotVld[k]      <= 1'b0;
        slotMemToReg[k] <= 1'b0;
        slotRegWr[k]    <= 1'b0;
        slotDr[k]       <= '0;
        slotResult[k]   <= '0;
      end
      headMemWr  <= 1'b0;
      headAlu    <= '0;
      headStData <= '0;
    end else if (!hold) begin
      for (int k = 1; k < DEPTH; k++) begin
        slotVld[k]      <= slotVld[k-1];
        slotMemToReg[k] <= slotMemToReg[k-1];
        slotRegWr[k]    <= slotRegWr[k-1];
        slotDr[k]       <= slotDr[k-1];
        slotResult[k]   <= slotValue[k-1];
      end
      slotVld[0]      <= acceptVld;
      slotMemToReg[0] <= in_mem_to_reg;
      slotRegWr[0]    <= in_reg_wr;
      slotDr[0]       <= in_dr;
      slotResult[0]   <= in_jal ? in_pc_inc : in_alu;
      headMemWr       <= in_mem_wr;
      headAlu         <= in_alu;
      headStData      <= in_st_data;
    end
  end

  // Scan oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    fwd_data = src_rf;
    fwd_hit  = '0;
`ifdef PIPE_FWD_LOAD_STALL_EN
    loadMatch = '0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slotVld[k] && slotRegWr[k] && (slotDr[k] == src_idx[i*RW +: RW])) begin
          fwd_data[i*DBITS +: DBITS] = slotValue[k];
          fwd_hit[i]                 = 1'b1;
`ifdef PIPE_FWD_LOAD_STALL_EN
          loadMatch[i] = (k == 0) && slotMemToReg[0];
`endif
        end
      end
`ifdef PIPE_FWD_LOAD_STALL_EN
      if (loadMatch[i]) begin
        fwd_data[i*DBITS +: DBITS] = src_rf[i*DBITS +: DBITS];
        fwd_hit[i]                 = 1'b0;
      end
`endif
    end
  end

`ifdef PIPE_FWD_LOAD_STALL_EN
  assign hazard_stall = |loadMatch;
`else
  assign hazard_stall = 1'b0;
`endif

  assign mem_addr   = headAlu;
  assign mem_din    = headStData;
  assign mem_wrt_en = slotVld[0] & headMemWr & ~hold;
  assign wb_wrt_en  = slotVld[LAST] & slotRegWr[LAST] & ~hold;
  assign wb_dr      = slotDr[LAST];
  assign wb_data    = slotValue[LAST];
endmodule
